// File: rtl/riscv_hs_throttle.sv
`default_nettype none
// =============================================================================
// Module : riscv_hs_throttle
// Inline rdy/ack gate injecting fixed or LFSR-random stall/burst windows.
// Rev    : 1.0  initial release
// =============================================================================
module riscv_hs_throttle #(
   parameter int          CHANNELS  = 1,
   parameter int          STALL_MIN = 1,
   parameter int          STALL_MAX = 5,
   parameter int          BURST_MIN = 1,
   parameter int          BURST_MAX = 3,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [1:0]          mode,
   input  logic [CHANNELS-1:0] rdy_in,
   output logic [CHANNELS-1:0] ack_in,
   output logic [CHANNELS-1:0] rdy_out,
   input  logic [CHANNELS-1:0] ack_out,
   output logic [CHANNELS-1:0] stalled
);

   localparam logic [1:0]  MODE_BYPASS = 2'd0;
   localparam logic [1:0]  MODE_FIXED  = 2'd1;
   localparam logic [1:0]  MODE_RANDOM = 2'd2;
   localparam logic [1:0]  MODE_BLOCK  = 2'd3;
   localparam int          S_RANGE     = STALL_MAX - STALL_MIN + 1;
   localparam int          B_RANGE     = BURST_MAX - BURST_MIN + 1;
   localparam logic [15:0] LFSR_MASK   = 16'hB400;

   typedef enum logic [0:0] {
      ST_STALL = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // With no stall window configured the channel comes out of reset already open.
   localparam state_t RST_STATE = state_t'((STALL_MAX == 0) ? ST_BURST : ST_STALL);

   if (BURST_MIN < 1) begin : g_chk_burst_min
      $error("riscv_hs_throttle: BURST_MIN must be >= 1");
   end
   if (S_RANGE < 1 || S_RANGE > 256 || B_RANGE < 1 || B_RANGE > 256) begin : g_chk_ranges
      $error("riscv_hs_throttle: stall/burst ranges must span 1..256 values");
   end

   logic fsm_en;
   logic bypass;

   always_comb begin
      fsm_en = rstn && ((mode == MODE_FIXED) || (mode == MODE_RANDOM));
      bypass = (mode == MODE_BYPASS);
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [15:0] SEED_RAW = SEED ^ 16'(i * 16'h9E37);
      localparam logic [15:0] SEED_CH  = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

      state_t      state_q, state_d;
      logic [7:0]  stall_cnt_q, stall_cnt_d;
      logic [8:0]  burst_cnt_q, burst_cnt_d;
      logic [15:0] lfsr_q, lfsr_d;
      logic [7:0]  s_off;
      logic [8:0]  b_off;
      logic [7:0]  s_draw;
      logic [8:0]  b_draw;
      logic        open;
      logic        xfer;

      always_comb begin
         s_off = 8'({1'b0, lfsr_q[7:0]} % 9'(S_RANGE));
         b_off = {1'b0, lfsr_q[15:8]} % 9'(B_RANGE);
         if (mode == MODE_RANDOM) begin
            s_draw = 8'(STALL_MIN) + s_off;
            b_draw = 9'(BURST_MIN) + b_off;
         end else begin
            s_draw = 8'(STALL_MAX);
            b_draw = 9'(BURST_MAX);
         end
      end

      always_comb begin
         open   = bypass || (fsm_en && (state_q == ST_BURST));
         xfer   = open && rdy_in[i] && ack_out[i];
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      end

      always_comb begin
         state_d     = state_q;
         stall_cnt_d = stall_cnt_q;
         burst_cnt_d = burst_cnt_q;
         if (!fsm_en) begin
            state_d     = RST_STATE;
            stall_cnt_d = 8'(STALL_MAX);
            burst_cnt_d = 9'(BURST_MAX);
         end else begin
            case (state_q)
               ST_STALL: begin
                  if (stall_cnt_q <= 8'd1) begin
                     state_d = ST_BURST;
                  end else begin
                     stall_cnt_d = stall_cnt_q - 8'd1;
                  end
               end
               ST_BURST: begin
                  // Windows only change on a completed transfer, so a pending rdy is never dropped.
                  if (xfer) begin
                     if (burst_cnt_q <= 9'd1) begin
                        burst_cnt_d = b_draw;
                        if (s_draw != 8'd0) begin
                           state_d     = ST_STALL;
                           stall_cnt_d = s_draw;
                        end
                     end else begin
                        burst_cnt_d = burst_cnt_q - 9'd1;
                     end
                  end
               end
               default: state_d = RST_STATE;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!rstn) begin
            state_q     <= RST_STATE;
            stall_cnt_q <= 8'(STALL_MAX);
            burst_cnt_q <= 9'(BURST_MAX);
            lfsr_q      <= SEED_CH;
         end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            lfsr_q      <= lfsr_d;
         end
      end

      assign rdy_out[i] = open & rdy_in[i];
      assign ack_in[i]  = open & ack_out[i];
      assign stalled[i] = ~open;

`ifdef RISCV_SIM
      a_block_mid_handshake : assert property (@(posedge clk) disable iff (!rstn)
         (rdy_out[i] && !ack_out[i]) |=> (mode != MODE_BLOCK));
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_hs_throttle.sv
`default_nettype none
// =============================================================================
// Module : tb_riscv_hs_throttle
// Directed self-checking bench for riscv_hs_throttle (three configurations).
// Rev    : 1.0  initial release
// =============================================================================
module tb_riscv_hs_throttle;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // dut_a: 1 channel, stall 1..2, burst 1..3
   logic       a_rstn, a_rdy_in, a_ack_in, a_rdy_out, a_ack_out, a_stalled;
   logic [1:0] a_mode;
   // dut_b: 1 channel, stall 0..3, burst 1..4
   logic       b_rstn, b_rdy_in, b_ack_in, b_rdy_out, b_ack_out, b_stalled;
   logic [1:0] b_mode;
   // dut_c: 2 channels, default windows
   logic       c_rstn;
   logic [1:0] c_mode, c_rdy_in, c_ack_in, c_rdy_out, c_ack_out, c_stalled;

   riscv_hs_throttle #(.CHANNELS(1), .STALL_MIN(1), .STALL_MAX(2), .BURST_MIN(1), .BURST_MAX(3))
   dut_a (.clk(clk), .rstn(a_rstn), .mode(a_mode), .rdy_in(a_rdy_in), .ack_in(a_ack_in),
          .rdy_out(a_rdy_out), .ack_out(a_ack_out), .stalled(a_stalled));

   riscv_hs_throttle #(.CHANNELS(1), .STALL_MIN(0), .STALL_MAX(3), .BURST_MIN(1), .BURST_MAX(4))
   dut_b (.clk(clk), .rstn(b_rstn), .mode(b_mode), .rdy_in(b_rdy_in), .ack_in(b_ack_in),
          .rdy_out(b_rdy_out), .ack_out(b_ack_out), .stalled(b_stalled));

   riscv_hs_throttle #(.CHANNELS(2))
   dut_c (.clk(clk), .rstn(c_rstn), .mode(c_mode), .rdy_in(c_rdy_in), .ack_in(c_ack_in),
          .rdy_out(c_rdy_out), .ack_out(c_ack_out), .stalled(c_stalled));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          n, cyc, closed, mism, run_c, run_o, max_open, c_bad;
   int          c_hist [0:3];
   bit          s_seen [0:3];
   bit          b_seen [1:4];
   logic [15:0] m_lfsr;
   bit          m_burst;
   int          m_sc, m_bc, s, b;
   logic [99:0] seq0, seq1;

   initial begin
      a_rstn = 1'b0; a_mode = 2'd1; a_rdy_in = 1'b1; a_ack_out = 1'b1;
      b_rstn = 1'b0; b_mode = 2'd2; b_rdy_in = 1'b1; b_ack_out = 1'b1;
      c_rstn = 1'b0; c_mode = 2'd2; c_rdy_in = 2'b11; c_ack_out = 2'b11;
      tick();
      tick();

      // Reset: closed in FIXED, transparent in BYPASS
      #1;
      chk("rst_gate_fixed", {a_stalled, a_rdy_out, a_ack_in}, 3'b100);
      a_mode = 2'd0;
      #1;
      chk("rst_gate_bypass", {a_stalled, a_rdy_out, a_ack_in}, 3'b011);
      a_mode = 2'd1;

      // T1: 2 closed, 3 open, period 5
      a_rstn = 1'b1;
      for (int k = 0; k < 15; k++) begin
         #1;
         chk("t1_fixed_pattern", {a_stalled, a_rdy_out, a_ack_in}, (k % 5 >= 2) ? 3'b011 : 3'b100);
         tick();
      end

      // T2: bypass is a pure wire
      a_mode = 2'd0;
      for (int k = 0; k < 1000; k++) begin
         a_rdy_in  = 1'($urandom);
         a_ack_out = 1'($urandom);
         #1;
         chk("t2_bypass", {a_rdy_out, a_ack_in, a_stalled}, {a_rdy_in, a_ack_out, 1'b0});
         tick();
      end

      // T3: block, then first open after STALL_MAX closed cycles
      a_mode = 2'd3; a_rdy_in = 1'b1; a_ack_out = 1'b1;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (a_rdy_out && a_ack_out) n++;
         chk("t3_block_stalled", a_stalled, 1'b1);
         tick();
      end
      chk("t3_block_no_xfer", n, 0);
      a_mode = 2'd1;
      closed = 0;
      #1;
      while (a_stalled && closed < 20) begin
         closed++;
         tick();
         #1;
      end
      chk("t3_closed_before_open", closed, 2);

      // T4: ack withheld for 7 cycles mid-burst; burst count must hold
      a_ack_out = 1'b0;
      #1;
      for (int k = 0; k < 7; k++) begin
         chk("t4_hold_open", {a_stalled, a_rdy_out, a_ack_in}, 3'b010);
         tick();
         #1;
      end
      a_ack_out = 1'b1;
      n = 0; cyc = 0;
      #1;
      while (!a_stalled && cyc < 10) begin
         if (a_rdy_out && a_ack_out) n++;
         cyc++;
         tick();
         #1;
      end
      chk("t4_burst_xfers", n, 3);
      tick();
      #1;
      chk("t4_stall_second", a_stalled, 1'b1);
      tick();
      #1;
      chk("t4_reopen", a_stalled, 1'b0);

      // T5: random windows against a reference model, plus run-length coverage
      m_lfsr = 16'hACE1; m_burst = 1'b0; m_sc = 3; m_bc = 4;
      mism = 0; run_c = 0; run_o = 0; max_open = 0; c_bad = 0;
      for (int k = 0; k < 4; k++) begin c_hist[k] = 0; s_seen[k] = 1'b0; b_seen[k + 1] = 1'b0; end
      b_rstn = 1'b1;
      for (int k = 0; k < 20000; k++) begin
         #1;
         if (b_stalled !== !m_burst || b_rdy_out !== m_burst) mism++;
         if (b_stalled) begin
            if (run_o > max_open) max_open = run_o;
            run_o = 0;
            run_c++;
         end else begin
            if (run_c > 0) begin
               if (run_c > 3) c_bad++;
               else c_hist[run_c]++;
            end
            run_c = 0;
            run_o++;
         end
         s = int'(m_lfsr[7:0]) % 4;
         b = 1 + int'(m_lfsr[15:8]) % 4;
         if (!m_burst) begin
            if (m_sc <= 1) m_burst = 1'b1;
            else m_sc--;
         end else if (m_bc <= 1) begin
            m_bc = b;
            s_seen[s] = 1'b1;
            b_seen[b] = 1'b1;
            if (s != 0) begin m_burst = 1'b0; m_sc = s; end
         end else begin
            m_bc--;
         end
         m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
         tick();
      end
      chk("t5_model_mismatch", mism, 0);
      for (int k = 0; k < 4; k++) chk($sformatf("t5_stall_drawn_%0d", k), s_seen[k], 1'b1);
      for (int k = 1; k <= 4; k++) chk($sformatf("t5_burst_drawn_%0d", k), b_seen[k], 1'b1);
      for (int k = 1; k <= 3; k++) chk($sformatf("t5_closed_run_%0d", k), c_hist[k] != 0, 1'b1);
      chk("t5_closed_run_out_of_range", c_bad, 0);
      chk("t5_back_to_back_bursts", max_open > 4, 1'b1);

      // T6: two channels diverge; reset pulse mid-burst closes both for STALL_MAX
      c_rstn = 1'b1;
      for (int k = 0; k < 100; k++) begin
         #1;
         seq0[k] = c_stalled[0];
         seq1[k] = c_stalled[1];
         tick();
      end
      chk("t6_channels_differ", seq0 != seq1, 1'b1);
      cyc = 0;
      #1;
      while (c_stalled[0] && cyc < 50) begin
         cyc++;
         tick();
         #1;
      end
      chk("t6_found_burst", c_stalled[0], 1'b0);
      c_rstn = 1'b0;
      #1;
      chk("t6_closed_in_reset", c_stalled, 2'b11);
      tick();
      c_rstn = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("t6_post_reset_window", c_stalled, (k < 5) ? 2'b11 : 2'b00);
         tick();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
